// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing logic.
// Contents:
//   ALU_OP_ADD / ALU_OP_SUB : per-requester op bit encoding (drives adder cin)
//   state_t                 : sequencer FSM encoding (IDLE, EXEC, RESP)
package alu_pkg;

    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-set-bit search.
// Ports:
//   vec [N]    : candidate request bits
//   ptr [ID_W] : search start position (must be < N)
//   any        : at least one bit of vec is set
//   idx [ID_W] : first set bit at or above ptr, wrapping modulo N
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    vec,
    input  logic [ID_W-1:0] ptr,
    output logic            any,
    output logic [ID_W-1:0] idx
);

    always_comb begin
        int               p;
        logic [ID_W-1:0]  pos;
        any = 1'b0;
        idx = '0;
        p   = 0;
        pos = '0;
        // Walk from the farthest offset down to offset 0 so the closest
        // set bit to ptr is the last one written and therefore wins.
        for (int k = N - 1; k >= 0; k--) begin
            p = int'(ptr) + k;
            if (p >= N) begin
                p = p - N;
            end
            pos = p[ID_W-1:0];
            if (vec[pos]) begin
                any = 1'b1;
                idx = pos;
            end
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter/sequencer in front of one shared 8-bit add/sub unit.
// One operation is in flight at a time: IDLE grants and registers operands,
// EXEC lets the external adder settle and captures its result, RESP holds
// the tagged result until the consumer takes it.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-requester operation handshake (N_REQ bits)
//   req_a, req_b          : packed operands, requester i at [8i+7:8i]
//   req_op                : per-requester op bit (0 add, 1 subtract)
//   add_a, add_b, add_cin : registered operands/op driven to the shared unit
//   add_sum, add_cout     : result returned by the shared unit
//   rsp_valid/rsp_ready   : response handshake
//   rsp_id, rsp_sum, rsp_cout : response tag and captured result
//   dbg_state             : current FSM state (alu_pkg::state_t encoding)
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Ready never depends on the same channel's ready from the other
// side; req_ready is a function of req_valid, the pointer and the state only.
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*8-1:0] req_a,
    input  logic [N_REQ*8-1:0] req_b,
    input  logic [N_REQ-1:0]   req_op,
    output logic [7:0]         add_a,
    output logic [7:0]         add_b,
    output logic               add_cin,
    input  logic [7:0]         add_sum,
    input  logic               add_cout,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [7:0]         rsp_sum,
    output logic               rsp_cout,
    output logic [1:0]         dbg_state
);

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] grant;
    logic            grant_any;
    logic            accept;
    logic [ID_W-1:0] ptr_nxt;

    rr_pick #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .vec (req_valid),
        .ptr (ptr),
        .any (grant_any),
        .idx (grant)
    );

    // rst_n gates ready so nothing is offered while reset is held.
    assign accept    = rst_n && (state == IDLE) && grant_any;
    assign ptr_nxt   = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
    assign dbg_state = state;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_valid && rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            add_a     <= '0;
            add_b     <= '0;
            add_cin   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                add_a   <= req_a[{grant, 3'b000} +: 8];
                add_b   <= req_b[{grant, 3'b000} +: 8];
                add_cin <= req_op[grant];
                rsp_id  <= grant;
                ptr     <= ptr_nxt;
            end
            if (state == EXEC) begin
                rsp_sum   <= add_sum;
                rsp_cout  <= add_cout;
                rsp_valid <= 1'b1;
            end
            if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
